// File: rtl/fpu_issue.sv
// Single-outstanding issue stage between the core and a multi-cycle FPU.
// Illegal ops and FPU timeouts answer with an error response and bump err_count.
module fpu_issue #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_tag,
    output logic [3:0]  fpu_ctl,
    output logic [31:0] fpu_x1,
    output logic [31:0] fpu_x2,
    output logic        fpu_en,
    input  logic        fpu_ready,
    input  logic [31:0] fpu_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_tag,
    output logic        rsp_err,
    output logic        busy,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] wait_cnt;
    logic       op_legal;
    logic       req_fire;
    logic       rsp_fire;
    logic       wait_last;

    assign op_legal  = (req_op <= 4'd5) || ((req_op >= 4'd9) && (req_op <= 4'd12));
    // Gated by rstn so the core sees no ready while reset is held.
    assign req_ready = (state == IDLE) && rstn;
    assign req_fire  = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign busy      = (state != IDLE);
    assign wait_last = (wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_fire) begin
                    state_nx = op_legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (fpu_ready || wait_last) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fpu_en    <= 1'b0;
            fpu_ctl   <= '0;
            fpu_x1    <= '0;
            fpu_x2    <= '0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
            err_count <= '0;
        end else begin
            fpu_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_fire) begin
                        rsp_tag <= req_tag;
                        if (op_legal) begin
                            fpu_ctl <= req_op;
                            fpu_x1  <= req_a;
                            fpu_x2  <= req_b;
                            fpu_en  <= 1'b1;
                        end else begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    // A completion on the final wait cycle takes priority over the timeout.
                    if (fpu_ready) begin
                        rsp_data <= fpu_y;
                        rsp_err  <= 1'b0;
                    end else if (wait_last) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_fire && rsp_err && (err_count != 8'hFF)) begin
                        err_count <= err_count + 8'd1;
                    end
                end
                default: begin
                    fpu_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue.sv
// Self-checking bench for fpu_issue: transaction-level reference model,
// per-cycle output comparison, directed scenarios and randomized traffic.
module tb_fpu_issue;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [4:0]  req_tag = '0;
    logic [3:0]  fpu_ctl;
    logic [31:0] fpu_x1;
    logic [31:0] fpu_x2;
    logic        fpu_en;
    logic        fpu_ready = 1'b0;
    logic [31:0] fpu_y = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  err_count;

    fpu_issue #(.TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .fpu_ctl(fpu_ctl), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_en(fpu_en),
        .fpu_ready(fpu_ready), .fpu_y(fpu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {[4'd0:4'd5], [4'd9:4'd12]};
    endfunction

    // Reference model: one request in flight, counted in whole wait cycles.
    bit          m_infl = 0, m_issued = 0, m_resp = 0, m_en = 0, m_rerr = 0;
    int          m_nwait = 0, m_errs = 0;
    logic [3:0]  m_op = '0;
    logic [31:0] m_a = '0, m_b = '0, m_rdata = '0;
    logic [4:0]  m_tag = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_infl <= 0; m_issued <= 0; m_resp <= 0; m_en <= 0; m_rerr <= 0;
            m_nwait <= 0; m_errs <= 0; m_op <= '0; m_a <= '0; m_b <= '0;
            m_rdata <= '0; m_tag <= '0;
        end else begin
            m_en <= 0;
            if (m_resp) begin
                if (rsp_ready) begin
                    m_resp <= 0;
                    if (m_rerr && m_errs < 255) m_errs <= m_errs + 1;
                end
            end else if (m_infl) begin
                if (!m_issued) begin
                    m_issued <= 1; m_nwait <= 0;
                end else if (fpu_ready) begin
                    m_infl <= 0; m_resp <= 1; m_rdata <= fpu_y; m_rerr <= 0;
                end else if (m_nwait + 1 == TO) begin
                    m_infl <= 0; m_resp <= 1; m_rdata <= '0; m_rerr <= 1;
                end else begin
                    m_nwait <= m_nwait + 1;
                end
            end else if (req_valid) begin
                m_op <= req_op; m_a <= req_a; m_b <= req_b; m_tag <= req_tag;
                if (is_legal(req_op)) begin
                    m_infl <= 1; m_issued <= 0; m_en <= 1;
                end else begin
                    m_resp <= 1; m_rdata <= '0; m_rerr <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("req_ready", 32'(req_ready), 32'(rstn && !m_infl && !m_resp));
        chk("busy", 32'(busy), 32'(m_infl || m_resp));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
        chk("fpu_en", 32'(fpu_en), 32'(m_en));
        chk("err_count", 32'(err_count), 32'(m_errs));
        if (!rstn) begin
            chk("rst_outs", {fpu_ctl, 22'(rsp_tag), 5'(rsp_err)}, 32'h0);
            chk("rst_x1", fpu_x1, 32'h0);
            chk("rst_x2", fpu_x2, 32'h0);
            chk("rst_data", rsp_data, 32'h0);
        end
        if (m_resp) begin
            chk("rsp_data", rsp_data, m_rdata);
            chk("rsp_tag", 32'(rsp_tag), 32'(m_tag));
            chk("rsp_err", 32'(rsp_err), 32'(m_rerr));
        end
        if (m_infl) begin
            chk("fpu_ctl", 32'(fpu_ctl), 32'(m_op));
            chk("fpu_x1", fpu_x1, m_a);
            chk("fpu_x2", fpu_x2, m_b);
        end
    end

    // Observations of the last transaction, used for literal expectations.
    logic [31:0] c_data;
    logic [4:0]  c_tag;
    logic        c_err;
    int          c_k, c_en;
    bit          c_ctl_bad;

    // Issue one request; the FPU answers in wait cycle `lat` with `y`,
    // the core holds off rsp_ready for `hold` response cycles.
    task automatic do_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input int lat, input logic [31:0] y,
                          input int hold, input bit press);
        bit ok = 0, done = 0, lg;
        int seen = 0;
        lg = is_legal(op);
        req_valid = 1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) ok = 1;
            @(posedge clk); #1;
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 0;
            return;
        end
        req_valid = 0; req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
        req_tag = 5'($urandom);
        c_en = 0; c_ctl_bad = 0; c_k = -1;
        for (int k = 0; k < 60 && !done; k++) begin
            if (k == 0) fpu_ready = 1'($urandom);
            else        fpu_ready = (k == lat);
            fpu_y = (k == lat) ? y : $urandom;
            if (press && seen > 0) begin
                req_valid = 1; req_op = 4'($urandom_range(0, 5));
            end
            @(negedge clk);
            if (fpu_en === 1'b1) c_en++;
            if (rsp_valid === 1'b1) begin
                if (seen == 0) begin
                    c_data = rsp_data; c_tag = rsp_tag; c_err = rsp_err; c_k = k;
                end
                seen++;
                if (seen > hold) begin
                    rsp_ready = 1; done = 1;
                end
            end else if (lg && (fpu_ctl !== op || fpu_x1 !== a || fpu_x2 !== b)) begin
                c_ctl_bad = 1;
            end
            @(posedge clk); #1;
            rsp_ready = 0;
        end
        req_valid = 0; fpu_ready = 0;
        if (!done) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            fpu_ready = 1'($urandom); fpu_y = $urandom; rsp_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        fpu_ready = 0; rsp_ready = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rstn = 1;
        @(negedge clk);
        chk("first_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // fadd 1.0 + 2.0
        do_req(4'd0, 32'h3F800000, 32'h40000000, 5'd3, 2, 32'h40400000, 0, 0);
        chk("add_data", c_data, 32'h40400000);
        chk("add_tag", 32'(c_tag), 32'd3);
        chk("add_err", 32'(c_err), 32'd0);
        chk("add_en_cycles", 32'(c_en), 32'd1);
        chk("add_lat", 32'(c_k), 32'd3);
        chk("add_stable", 32'(c_ctl_bad), 32'd0);
        idle(2);

        // feq then a long fdiv
        do_req(4'd9, 32'h3F800000, 32'h3F800000, 5'd7, 1, 32'h00000001, 1, 0);
        chk("feq_data", c_data, 32'h00000001);
        chk("feq_err", 32'(c_err), 32'd0);
        do_req(4'd4, 32'h40C00000, 32'h40000000, 5'd8, 9, 32'h40400000, 0, 0);
        chk("div_stable", 32'(c_ctl_bad), 32'd0);
        chk("div_lat", 32'(c_k), 32'd10);
        chk("div_en_cycles", 32'(c_en), 32'd1);

        // illegal op
        do_req(4'd7, 32'h12345678, 32'h9ABCDEF0, 5'd12, 1, 32'hDEADBEEF, 0, 0);
        chk("ill_lat", 32'(c_k), 32'd0);
        chk("ill_data", c_data, 32'h0);
        chk("ill_err", 32'(c_err), 32'd1);
        chk("ill_tag", 32'(c_tag), 32'd12);
        chk("ill_en_cycles", 32'(c_en), 32'd0);
        @(negedge clk);
        chk("ill_errcnt", 32'(err_count), 32'd1);
        @(posedge clk); #1;

        // timeout, with a late completion pulse landing in RESP
        do_req(4'd2, 32'h11111111, 32'h22222222, 5'd5, TO + 3, 32'hCAFEF00D, 5, 0);
        chk("to_lat", 32'(c_k), 32'(TO + 1));
        chk("to_err", 32'(c_err), 32'd1);
        chk("to_data", c_data, 32'h0);
        @(negedge clk);
        chk("to_errcnt", 32'(err_count), 32'd2);
        @(posedge clk); #1;

        // completion on the last wait cycle beats the timeout
        do_req(4'd3, 32'h33333333, 32'h44444444, 5'd9, TO, 32'h55AA55AA, 0, 0);
        chk("tie_err", 32'(c_err), 32'd0);
        chk("tie_data", c_data, 32'h55AA55AA);
        chk("tie_lat", 32'(c_k), 32'(TO + 1));

        // backpressured response with a competing request
        do_req(4'd1, 32'h0BADF00D, 32'h00C0FFEE, 5'd21, 4, 32'h77777777, 5, 1);
        chk("bp_lat", 32'(c_k), 32'd5);
        chk("bp_data", c_data, 32'h77777777);
        idle(1);

        // reset while waiting on the FPU
        req_valid = 1; req_op = 4'd5; req_a = 32'hA5A5A5A5; req_b = 32'h5A5A5A5A; req_tag = 5'd30;
        @(negedge clk);
        chk("mr_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 0;
        repeat (3) begin @(posedge clk); #1; end
        rstn = 0;
        @(negedge clk);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_ctl", 32'(fpu_ctl), 32'd0);
        chk("mr_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rstn = 1; fpu_ready = 1; fpu_y = 32'hFFFF0000;
        @(posedge clk); #1;
        fpu_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mr_no_rsp", 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk("mr_errcnt", 32'(err_count), 32'd0);
        do_req(4'd10, 32'h01020304, 32'h05060708, 5'd17, 3, 32'h0000ABCD, 0, 0);
        chk("mr_next_data", c_data, 32'h0000ABCD);
        chk("mr_next_err", 32'(c_err), 32'd0);

        // randomized traffic
        for (int t = 0; t < 150; t++) begin
            do_req(4'($urandom), $urandom, $urandom, 5'($urandom),
                   int'($urandom_range(1, TO + 3)), $urandom,
                   int'($urandom_range(0, 3)), 1'($urandom));
            idle(int'($urandom_range(0, 2)));
        end

        // error counter saturation
        for (int t = 0; t < 260; t++) begin
            do_req(4'd13 + 4'($urandom_range(0, 2)), $urandom, $urandom, 5'($urandom), 1, 32'h0, 0, 0);
        end
        @(negedge clk);
        chk("sat_errcnt", 32'(err_count), 32'd255);
        @(posedge clk); #1;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_issue.md
FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max WAIT cycles allowed before fpu_ready, legal range 2..255.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req_valid in 1, req_ready out 1: core-side request handshake; transfer when both high at a rising edge.
REQ-005 SHALL have ports req_op in 4, req_a in 32, req_b in 32, req_tag in 5: FPU op code, operands, destination register tag.
REQ-006 SHALL have ports fpu_ctl out 4, fpu_x1 out 32, fpu_x2 out 32, fpu_en out 1: FPU op select, operands, start strobe.
REQ-007 SHALL have ports fpu_ready in 1, fpu_y in 32: FPU completion pulse and result.
REQ-008 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out 32, rsp_tag out 5, rsp_err out 1: writeback handshake, result, tag, error flag.
REQ-009 SHALL have ports busy out 1 (state != IDLE) and err_count out 8 (saturating error count).

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-011 Legal ops SHALL be 0-5 and 9-12; all others (6,7,8,13,14,15) illegal.
REQ-012 IDLE: req_ready=1; on transfer latch op/a/b/tag; legal op -> ISSUE, illegal op -> RESP with rsp_data=0, rsp_err=1, fpu_en never asserted.
REQ-013 ISSUE: fpu_en=1 for exactly one cycle with fpu_ctl/fpu_x1/fpu_x2 = latched values; clear wait counter; -> WAIT.
REQ-014 fpu_ctl, fpu_x1, fpu_x2 SHALL stay stable from ISSUE until the edge fpu_ready is sampled in WAIT.
REQ-015 WAIT: on fpu_ready=1 capture rsp_data=fpu_y, rsp_err=0 -> RESP; else counter+1.
REQ-016 WAIT with counter reaching TIMEOUT and no fpu_ready SHALL -> RESP with rsp_data=0, rsp_err=1.
REQ-017 fpu_ready=1 in IDLE, ISSUE or RESP SHALL be ignored; no state or data change.
REQ-018 fpu_ready and timeout on the same edge: fpu_ready wins, rsp_err=0.
REQ-019 RESP: rsp_valid=1; rsp_data, rsp_tag, rsp_err stable until rsp_ready=1 sampled; then -> IDLE, rsp_valid=0 next cycle.
REQ-020 req_ready SHALL be 0 in every state except IDLE; no request accepted while busy.
REQ-021 err_count SHALL increment by 1 on each RESP handshake with rsp_err=1, saturating at 255.
REQ-022 Latency: accept edge T, fpu_en high in cycle T+1, rsp_valid high one cycle after the edge sampling fpu_ready.
REQ-023 fpu_en SHALL be a registered output and never high two consecutive cycles.

Reset
REQ-024 rstn low SHALL force immediately: state IDLE, req_ready=0, fpu_en=0, fpu_ctl=0, fpu_x1=0, fpu_x2=0, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, busy=0, err_count=0, wait counter=0.
REQ-025 After rstn rises, req_ready SHALL be 1 in the first cycle.
REQ-026 Reset mid-operation (ISSUE/WAIT/RESP) SHALL discard the operation with no response; a late fpu_ready after release SHALL be ignored.

Verification
REQ-027 op=0, a=0x3F800000, b=0x40000000, tag=3, model FPU ready after 2 cycles -> fpu_en one cycle, fpu_ctl=0 held, rsp_data=0x40400000, rsp_tag=3, rsp_err=0.
REQ-028 op=9 (feq), a=b=0x3F800000 -> rsp_data=0x00000001, rsp_err=0; then op=4 (fdiv), model ready after 9 cycles -> fpu_ctl=4 stable all 9 cycles.
REQ-029 op=7, tag=12 -> rsp_valid one cycle after accept, rsp_data=0, rsp_err=1, rsp_tag=12, fpu_en stays 0, err_count=1.
REQ-030 op=2, fpu_ready held 0 -> rsp_err=1, rsp_data=0 after exactly TIMEOUT=15 WAIT cycles; a fpu_ready pulse 3 cycles later ignored.
REQ-031 rsp_ready=0 for 5 cycles in RESP -> rsp_valid/data/tag constant, req_ready=0 throughout, second req_valid not accepted until handshake.
REQ-032 rstn pulled low in WAIT, fpu_ready pulsed after release -> all outputs at reset values, no rsp_valid, next request completes normally.
